// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 memory path.
// Holds the sequencer state encoding, the default memory-mapped I/O address
// and a helper that converts an access length into a down-counter load value.
package slc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

  // Address decoded as the switch (read) / hex display (write) register.
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  // The counter runs from cycles-1 down to 0, so terminal count is reached
  // on the last ACCESS cycle without an extra compare against cycles.
  function automatic logic [3:0] wait_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable 4-bit down-counter with terminal-count flag.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   load        : load load_val on the next rising edge (has priority)
//   load_val    : value to load
//   dec         : decrement on the next rising edge (stops at 0)
//   tc          : high while the count is 0
module wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       tc
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_sequencer.sv
// SRAM / memory-mapped I/O access sequencer for the SLC-3 datapath.
// Sits between the MAR/MDR registers and the SRAM tristate buffer and
// generates the active-low SRAM strobes for each CPU access.
// Ports:
//   Clk, Reset          : clock, asynchronous active-low reset
//   Req, Wr, Addr, Wdata: CPU request (sampled only in IDLE)
//   Rdata               : read data, held until the next read completes
//   Ack                 : one-cycle completion pulse
//   Busy                : high whenever the sequencer is not IDLE
//   Switches, Hex_Out   : board switches / hex display register (at IO_ADDR)
//   CE, UB, LB, OE, WE  : active-low SRAM strobes
//   SRAM_ADDR           : 20-bit SRAM address (upper nibble zero)
//   Sram_Dout, Sram_Drive, Sram_Din : tristate buffer data and enable
module mem_sequencer
  import slc3_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] Wdata,
  output logic [15:0] Rdata,
  output logic        Ack,
  output logic        Busy,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_Out,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] Sram_Dout,
  output logic        Sram_Drive,
  input  logic [15:0] Sram_Din
);

  seq_state_t  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        wr_q, wr_d;
  logic        io_q, io_d;

  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_tc;

  wait_counter u_wait_counter (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (cnt_load),
    .load_val (wait_load(WAIT_CYCLES)),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  // Next-state and register updates. The request fields are latched once in
  // IDLE so that CPU-side changes during an access cannot disturb it.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    hex_d    = hex_q;
    wr_d     = wr_q;
    io_d     = io_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          addr_d  = Addr;
          wr_d    = Wr;
          wdata_d = Wdata;
          io_d    = (Addr == IO_ADDR);
          if (Addr == IO_ADDR) begin
            // I/O accesses complete in one cycle with no SRAM activity.
            state_d = ST_DONE;
            if (Wr) begin
              hex_d = Wdata;
            end else begin
              rdata_d = Switches;
            end
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        cnt_load = 1'b1;
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_tc) begin
          state_d = ST_DONE;
          if (!wr_q) begin
            rdata_d = Sram_Din;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobe decode. WE is only pulled low in ACCESS and OE only on reads, so
  // the two can never overlap; the buffer drives only on writes, so it never
  // fights an SRAM output enable.
  always_comb begin
    CE         = 1'b1;
    UB         = 1'b1;
    LB         = 1'b1;
    OE         = 1'b1;
    WE         = 1'b1;
    Sram_Drive = 1'b0;
    Ack        = 1'b0;
    Busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_SETUP: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        if (wr_q) begin
          Sram_Drive = 1'b1;
        end else begin
          OE = 1'b0;
        end
      end
      ST_ACCESS: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        if (wr_q) begin
          Sram_Drive = 1'b1;
          WE         = 1'b0;
        end else begin
          OE = 1'b0;
        end
      end
      ST_DONE: begin
        Ack = 1'b1;
        // Hold chip select and data one cycle past the WE rising edge.
        if (wr_q && !io_q) begin
          CE         = 1'b0;
          UB         = 1'b0;
          LB         = 1'b0;
          Sram_Drive = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      hex_q   <= 16'h0000;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      wr_q    <= wr_d;
      io_q    <= io_d;
    end
  end

  assign Rdata     = rdata_q;
  assign Hex_Out   = hex_q;
  assign SRAM_ADDR = {4'h0, addr_q};
  assign Sram_Dout = wdata_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: each transaction pushes its expected
// completion cycle, read data, hex value and strobe cycle counts; a negedge
// monitor pops and compares on every Ack.
module tb_mem_sequencer;

  localparam int W = 2;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] Wdata;
  logic [15:0] Rdata;
  logic        Ack;
  logic        Busy;
  logic [15:0] Switches;
  logic [15:0] Hex_Out;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] SRAM_ADDR;
  logic [15:0] Sram_Dout;
  logic        Sram_Drive;
  logic [15:0] Sram_Din;

  mem_sequencer #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .Wr         (Wr),
    .Addr       (Addr),
    .Wdata      (Wdata),
    .Rdata      (Rdata),
    .Ack        (Ack),
    .Busy       (Busy),
    .Switches   (Switches),
    .Hex_Out    (Hex_Out),
    .CE         (CE),
    .UB         (UB),
    .LB         (LB),
    .OE         (OE),
    .WE         (WE),
    .SRAM_ADDR  (SRAM_ADDR),
    .Sram_Dout  (Sram_Dout),
    .Sram_Drive (Sram_Drive),
    .Sram_Din   (Sram_Din)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          start;
    int          ack;
    logic        io;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] hex;
    int          we_n;
    int          oe_n;
    int          drv_n;
    int          ce_n;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_total = 0;
  logic [15:0] model_rdata = 16'h0000;
  logic [15:0] model_hex = 16'h0000;
  logic [15:0] cur_din = 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard compare on Ack.
  int          we_c, oe_c, drv_c, ce_c;
  logic [19:0] addr_seen;
  logic [15:0] dout_seen;
  logic        exp_busy;
  exp_t        e;

  always @(negedge Clk) begin
    if (!Reset) begin
      we_c = 0; oe_c = 0; drv_c = 0; ce_c = 0;
    end else begin
      check_eq("we_oe_excl", 32'(WE | OE), 32'd1);
      check_eq("drive_vs_oe", 32'(!(Sram_Drive && !OE)), 32'd1);
      exp_busy = (q.size() != 0) && (cyc >= q[0].start);
      check_eq("busy", 32'(Busy), 32'(exp_busy));
      if (!WE) begin we_c++; dout_seen = Sram_Dout; end
      if (!OE) oe_c++;
      if (Sram_Drive) drv_c++;
      if (!CE) begin ce_c++; addr_seen = SRAM_ADDR; end
      if (q.size() == 0) begin
        check_eq("ack_unexpected", 32'(Ack), 32'd0);
      end else if (Ack) begin
        e = q.pop_front();
        ack_total++;
        check_eq("ack_cycle", 32'(cyc), 32'(e.ack));
        check_eq("rdata", 32'(Rdata), 32'(e.rdata));
        check_eq("hex_out", 32'(Hex_Out), 32'(e.hex));
        check_eq("we_low_cycles", 32'(we_c), 32'(e.we_n));
        check_eq("oe_low_cycles", 32'(oe_c), 32'(e.oe_n));
        check_eq("drive_cycles", 32'(drv_c), 32'(e.drv_n));
        check_eq("ce_low_cycles", 32'(ce_c), 32'(e.ce_n));
        if (!e.io) check_eq("sram_addr", 32'(addr_seen), 32'({4'h0, e.addr}));
        if (!e.io && e.wr) check_eq("sram_dout", 32'(dout_seen), 32'(e.wdata));
        we_c = 0; oe_c = 0; drv_c = 0; ce_c = 0;
      end
    end
  end

  // Drive a request (to be sampled at the next rising edge) and push its
  // expected outcome.
  task automatic start_txn(input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] din);
    exp_t x;
    x.start = cyc + 1;
    x.io    = (addr == 16'hFFFF);
    x.wr    = wr;
    x.addr  = addr;
    x.wdata = wdata;
    x.we_n = 0; x.oe_n = 0; x.drv_n = 0; x.ce_n = 0;
    if (x.io) begin
      x.ack = x.start;
      if (wr) model_hex = wdata;
      else    model_rdata = din;
    end else begin
      x.ack = x.start + W + 1;
      if (wr) begin
        x.we_n = W; x.drv_n = W + 2; x.ce_n = W + 2;
      end else begin
        x.oe_n = W + 1; x.ce_n = W + 1;
        model_rdata = din;
      end
    end
    x.rdata = model_rdata;
    x.hex   = model_hex;
    q.push_back(x);
    Req      = 1'b1;
    Wr       = wr;
    Addr     = addr;
    Wdata    = wdata;
    cur_din  = din;
    Switches = (x.io && !wr) ? din : 16'($urandom);
    Sram_Din = 16'($urandom);
  endtask

  // Scramble the request fields once the request is taken, act as the SRAM
  // data source while OE is low, and wait (bounded) for completion.
  task automatic finish_txn(input bit keep_req);
    int n;
    @(posedge Clk); #1;
    Addr  = 16'($urandom);
    Wdata = 16'($urandom);
    Wr    = 1'($urandom);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge Clk); #1;
      Sram_Din = OE ? 16'($urandom) : cur_din;
      n++;
    end
    if (q.size() != 0) begin
      check_eq("ack_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    if (!keep_req) Req = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] din, input bit keep_req);
    @(posedge Clk); #1;
    start_txn(wr, addr, wdata, din);
    finish_txn(keep_req);
  endtask

  int base;

  initial begin
    Reset = 1'b0; Req = 1'b0; Wr = 1'b0; Addr = 16'h0; Wdata = 16'h0;
    Switches = 16'h0; Sram_Din = 16'h0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_rdata", 32'(Rdata), 32'h0);
    check_eq("rst_hex", 32'(Hex_Out), 32'h0);
    check_eq("rst_ack", 32'(Ack), 32'h0);
    check_eq("rst_busy", 32'(Busy), 32'h0);
    check_eq("rst_strobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    check_eq("rst_drive", 32'(Sram_Drive), 32'h0);
    Reset = 1'b1;

    run_txn(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    run_txn(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    run_txn(1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b0);
    run_txn(1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 1'b0);
    run_txn(1'b1, 16'h8001, 16'h5555, 16'h0000, 1'b0);

    // Req held high across three reads.
    base = ack_total;
    run_txn(1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b1);
    run_txn(1'b0, 16'h0021, 16'h0000, 16'h2222, 1'b1);
    run_txn(1'b0, 16'h0022, 16'h0000, 16'h3333, 1'b0);
    check_eq("b2b_ack_count", 32'(ack_total - base), 32'd3);

    // Reset during the ACCESS phase of a write.
    @(posedge Clk); #1;
    start_txn(1'b1, 16'h0040, 16'hCAFE, 16'h0000);
    @(posedge Clk);
    @(posedge Clk); #1;
    check_eq("abort_we_before", 32'(WE), 32'd0);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("abort_we", 32'(WE), 32'd1);
    check_eq("abort_drive", 32'(Sram_Drive), 32'd0);
    check_eq("abort_busy", 32'(Busy), 32'd0);
    check_eq("abort_ack", 32'(Ack), 32'd0);
    check_eq("abort_hex", 32'(Hex_Out), 32'd0);
    check_eq("abort_rdata", 32'(Rdata), 32'd0);
    q.delete();
    model_hex = 16'h0000;
    model_rdata = 16'h0000;
    Req = 1'b0;

    // Request set up during reset is taken at the first edge after release.
    @(posedge Clk); #1;
    start_txn(1'b1, 16'hFFFF, 16'h5A5A, 16'h0000);
    #2;
    Reset = 1'b1;
    finish_txn(1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = (i % 3 == 0) ? 16'hFFFF : (16'($urandom) & 16'h7FFF);
      run_txn(1'($urandom), a, 16'($urandom), 16'($urandom), 1'b0);
    end

    repeat (3) @(posedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
